// File: rtl/apb_spi_pkg.sv
// Shared types for the APB initiator that drives the SPI register block:
// APB phase encodings, SPI register addresses and the queued command word.
package apb_spi_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_t;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR  = 3'd5;

    typedef struct packed {
        logic       write;
        logic [2:0] addr;
        logic [7:0] wdata;
    } apb_cmd_t;

    localparam int CMD_W = $bits(apb_cmd_t);

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue in front of the APB sequencer. Head entry is visible
// combinationally so the sequencer can load it on the same edge it pops.
module apb_cmd_fifo
    import apb_spi_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [CMD_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [CMD_W-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(CMD_DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CMD_W-1:0] mem_q [CMD_DEPTH];
    logic [CMD_W-1:0] mem_d [CMD_DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator for the SPI register block: queues commands, runs SETUP/ACCESS
// and pulses a response per transfer. Optional ACCESS timeout: APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_spi_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [2:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    output logic       PSEL_o,
    output logic       PENABLE_o,
    output logic       PWRITE_o,
    output logic [2:0] PADDR_o,
    output logic [7:0] PWDATA_o,
    input  logic       PREADY_i,
    input  logic [7:0] PRDATA_i,
    input  logic       PSLVERR_i
);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_master_bridge: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    apb_state_t       state_q, state_d;
    apb_cmd_t         push_cmd;
    apb_cmd_t         head;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             xfer_timeout;
    logic             xfer_done;

    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [2:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;

    assign push_cmd = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    assign head     = apb_cmd_t'(fifo_head);

    apb_cmd_fifo #(
        .CMD_DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .clk        (PCLK),
        .rst_n      (PRESET_n),
        .push_i     (cmd_valid_i),
        .push_data_i(push_cmd),
        .pop_i      (fifo_pop),
        .pop_data_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Counts ACCESS cycles of the current transfer; the last allowed cycle aborts.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == APB_SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == APB_ACCESS) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign xfer_timeout = (state_q == APB_ACCESS) && !PREADY_i &&
                          (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign xfer_timeout = 1'b0;
`endif

    assign xfer_done = (state_q == APB_ACCESS) && (PREADY_i || xfer_timeout);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q     <= APB_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // A completing transfer with more work queued goes straight to SETUP.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = APB_SETUP;
                    fifo_pop = 1'b1;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (xfer_done) begin
                    if (!fifo_empty) begin
                        state_d  = APB_SETUP;
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = APB_IDLE;
                    end
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (state_q == APB_SETUP) begin
            penable_d = 1'b1;
        end

        if (xfer_done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (pwrite_q || xfer_timeout) ? 8'h00 : PRDATA_i;
            rsp_err_d   = PSLVERR_i || xfer_timeout;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
        end

        // Loading a new command overrides the completion drop so PSEL stays high.
        if (fifo_pop) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head.write;
            paddr_d   = head.addr;
            pwdata_d  = head.write ? head.wdata : 8'h00;
        end
    end

    assign cmd_ready_o = !fifo_full;
    assign busy_o      = !fifo_empty || (state_q != APB_IDLE);
    assign PSEL_o      = psel_q;
    assign PENABLE_o   = penable_q;
    assign PWRITE_o    = pwrite_q;
    assign PADDR_o     = paddr_q;
    assign PWDATA_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed APB scenarios plus random
// command batches against a register-file reference model and an APB slave model.
module tb_apb_master_bridge;

    logic       PCLK;
    logic       PRESET_n;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_write_i;
    logic [2:0] cmd_addr_i;
    logic [7:0] cmd_wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_err_o;
    logic       busy_o;
    logic       PSEL_o;
    logic       PENABLE_o;
    logic       PWRITE_o;
    logic [2:0] PADDR_o;
    logic [7:0] PWDATA_o;
    logic       PREADY_i;
    logic [7:0] PRDATA_i;
    logic       PSLVERR_i;

    apb_master_bridge #(
        .CMD_DEPTH     (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK       (PCLK),
        .PRESET_n   (PRESET_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o),
        .PSEL_o     (PSEL_o),
        .PENABLE_o  (PENABLE_o),
        .PWRITE_o   (PWRITE_o),
        .PADDR_o    (PADDR_o),
        .PWDATA_o   (PWDATA_o),
        .PREADY_i   (PREADY_i),
        .PRDATA_i   (PRDATA_i),
        .PSLVERR_i  (PSLVERR_i)
    );

    typedef struct {
        bit w;
        int a;
        int d;
    } tcmd_t;

    tcmd_t      exp_q[$];
    int         model_regs [8];
    logic [7:0] sregs [8];

    int n_cmp = 0;
    int n_bad = 0;
    int rsp_count = 0;
    int n_pushed = 0;
    int n_discarded = 0;

    int slave_waits = 0;
    int err_addr = -1;
    bit slave_hang = 0;
    int scnt = 0;

    tcmd_t mc;
    int    m_rd;
    bit    m_err;
    logic       prev_psel, prev_penable, prev_pwrite;
    logic [2:0] prev_paddr;
    logic [7:0] prev_pwdata;

    int addr_tab [5] = '{0, 1, 2, 3, 5};

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // APB slave: answers after slave_waits wait states, junk on the bus otherwise.
    initial begin
        PREADY_i  = 1'b0;
        PRDATA_i  = 8'h00;
        PSLVERR_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sregs[i]      = 8'h00;
            model_regs[i] = 0;
        end
        forever begin
            @(posedge PCLK);
            #2;
            if (PRESET_n && PSEL_o && PENABLE_o && !slave_hang && scnt >= slave_waits) begin
                PREADY_i  = 1'b1;
                PSLVERR_i = (int'(PADDR_o) == err_addr);
                if (PWRITE_o) begin
                    PRDATA_i = 8'($urandom);
                    if (!PSLVERR_i) sregs[PADDR_o] = PWDATA_o;
                end else begin
                    PRDATA_i = sregs[PADDR_o];
                end
                scnt = 0;
            end else begin
                PREADY_i  = 1'b0;
                PRDATA_i  = 8'($urandom);
                PSLVERR_i = 1'($urandom);
                scnt = (PRESET_n && PSEL_o && PENABLE_o) ? scnt + 1 : 0;
            end
        end
    end

    // Response scoreboard and APB protocol observer.
    always @(posedge PCLK) begin
        #1;
        if (PRESET_n) begin
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid_o, 0);
                end else begin
                    mc = exp_q.pop_front();
                    if (slave_hang) begin
                        m_rd  = 0;
                        m_err = 1;
                    end else begin
                        m_err = (mc.a == err_addr);
                        if (mc.w) begin
                            m_rd = 0;
                            if (!m_err) model_regs[mc.a] = mc.d;
                        end else begin
                            m_rd = model_regs[mc.a];
                        end
                    end
                    chk("rsp_rdata", rsp_rdata_o, m_rd);
                    chk("rsp_err", rsp_err_o, m_err);
                end
                rsp_count++;
            end
            if (PSEL_o && !PWRITE_o) chk("pwdata_read_zero", PWDATA_o, 0);
            if (PENABLE_o) chk("penable_needs_psel", PSEL_o, 1);
            if (prev_psel && (!prev_penable || !PREADY_i) && !rsp_valid_o) begin
                chk("hold_psel", PSEL_o, 1);
                chk("hold_penable", PENABLE_o, 1);
                chk("hold_paddr", PADDR_o, prev_paddr);
                chk("hold_pwrite", PWRITE_o, prev_pwrite);
                chk("hold_pwdata", PWDATA_o, prev_pwdata);
            end
            prev_psel    = PSEL_o;
            prev_penable = PENABLE_o;
            prev_pwrite  = PWRITE_o;
            prev_paddr   = PADDR_o;
            prev_pwdata  = PWDATA_o;
        end else begin
            chk("rsp_in_reset", rsp_valid_o, 0);
            prev_psel = 1'b0;
        end
    end

    task automatic push_cmd(input bit w, input int a, input int d);
        tcmd_t c;
        bit    ok;
        ok = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a[2:0];
        cmd_wdata_i = d[7:0];
        for (int i = 0; i < 300 && !ok; i++) begin
            if (cmd_ready_o) begin
                @(posedge PCLK);
                c.w = w;
                c.a = a;
                c.d = d;
                exp_q.push_back(c);
                n_pushed++;
                ok = 1;
            end
            @(negedge PCLK);
        end
        cmd_valid_i = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic wait_rsp(output bit found, output int acc);
        found = 0;
        acc   = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge PCLK);
            if (rsp_valid_o) found = 1;
            else if (PSEL_o && PENABLE_o) acc++;
        end
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge PCLK);
            if (exp_q.size() == 0 && !busy_o) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        int acc;
        int rc0;
        bit seen;

        PRESET_n    = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 3'd0;
        cmd_wdata_i = 8'h00;
        repeat (2) @(negedge PCLK);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_psel", PSEL_o, 0);
        chk("rst_penable", PENABLE_o, 0);
        chk("rst_pwrite", PWRITE_o, 0);
        chk("rst_paddr", PADDR_o, 0);
        chk("rst_pwdata", PWDATA_o, 0);
        PRESET_n = 1'b1;
        @(negedge PCLK);

        // Single write, slave one cycle late: four cycles to the response.
        slave_waits = 1;
        push_cmd(1, 0, 'h50);
        chk("t1_psel_accept_cycle", PSEL_o, 0);
        @(negedge PCLK);
        chk("t1_setup_psel", PSEL_o, 1);
        chk("t1_setup_penable", PENABLE_o, 0);
        chk("t1_setup_pwrite", PWRITE_o, 1);
        chk("t1_setup_paddr", PADDR_o, 0);
        chk("t1_setup_pwdata", PWDATA_o, 'h50);
        @(negedge PCLK);
        chk("t1_access_psel", PSEL_o, 1);
        chk("t1_access_penable", PENABLE_o, 1);
        @(negedge PCLK);
        chk("t1_wait_no_rsp", rsp_valid_o, 0);
        @(negedge PCLK);
        chk("t1_rsp_valid", rsp_valid_o, 1);
        chk("t1_rsp_err", rsp_err_o, 0);
        chk("t1_rsp_rdata", rsp_rdata_o, 0);
        @(negedge PCLK);
        chk("t1_rsp_pulse_end", rsp_valid_o, 0);
        chk("t1_idle_psel", PSEL_o, 0);
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_paddr_kept", PADDR_o, 0);
        chk("t1_idle_pwrite_kept", PWRITE_o, 1);

        // Read back the written value.
        push_cmd(0, 0, 'hA5);
        wait_rsp(f, acc);
        chk("t2_rsp_seen", f, 1);
        chk("t2_rdata", rsp_rdata_o, 'h50);
        chk("t2_access_cycles", acc, 2);

        // Three wait states: four ACCESS cycles, one response.
        slave_waits = 3;
        rc0 = rsp_count;
        push_cmd(1, 2, $urandom_range(0, 255));
        wait_rsp(f, acc);
        chk("t3_rsp_seen", f, 1);
        chk("t3_access_cycles", acc, 4);
        repeat (3) @(negedge PCLK);
        chk("t3_single_pulse", rsp_count - rc0, 1);

        // Five queued commands against a slow slave.
        rc0 = rsp_count;
        for (int i = 0; i < 5; i++) push_cmd($urandom_range(0, 1), addr_tab[i], $urandom_range(0, 255));
        chk("t4_ready_low_when_full", cmd_ready_o, 0);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            chk("t4_psel_no_bubble", PSEL_o, 1);
            @(negedge PCLK);
        end
        chk("t4_rsp_count", rsp_count - rc0, 5);
        drain("t4_drain");

        // Slave error on DR write, then a clean transfer clears the flag.
        slave_waits = 1;
        err_addr = 5;
        push_cmd(1, 5, 'h3C);
        wait_rsp(f, acc);
        chk("t5_err_seen", f, 1);
        chk("t5_err_set", rsp_err_o, 1);
        push_cmd(1, 1, 'h77);
        wait_rsp(f, acc);
        chk("t5_ok_seen", f, 1);
        chk("t5_err_clear", rsp_err_o, 0);
        drain("t5_drain");
        err_addr = -1;

        // Random batches of mixed traffic.
        for (int b = 0; b < 4; b++) begin
            slave_waits = $urandom_range(0, 3);
            err_addr = ($urandom_range(0, 2) == 0) ? -1 : addr_tab[$urandom_range(0, 4)];
            for (int k = 0; k < 12; k++) begin
                push_cmd($urandom_range(0, 1), addr_tab[$urandom_range(0, 4)], $urandom_range(0, 255));
                repeat ($urandom_range(0, 2)) @(negedge PCLK);
            end
            drain("rand_drain");
        end
        err_addr = -1;

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never answers: abort after the full ACCESS budget.
        slave_hang = 1;
        push_cmd(1, 2, 'h33);
        wait_rsp(f, acc);
        chk("t6_timeout_seen", f, 1);
        chk("t6_timeout_cycles", acc, 16);
        chk("t6_timeout_err", rsp_err_o, 1);
        chk("t6_timeout_rdata", rsp_rdata_o, 0);
        slave_hang = 0;
        drain("t6_timeout_drain");
`endif

        // Reset in the middle of ACCESS with more commands queued.
        slave_waits = 10;
        push_cmd(1, 3, 'h9E);
        push_cmd(0, 1, 0);
        push_cmd(1, 2, 'h11);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (PSEL_o && PENABLE_o) seen = 1;
            else @(negedge PCLK);
        end
        chk("t6_reach_access", seen, 1);
        @(negedge PCLK);
        PRESET_n = 1'b0;
        #1;
        chk("t6_rst_psel", PSEL_o, 0);
        chk("t6_rst_penable", PENABLE_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_ready", cmd_ready_o, 1);
        rc0 = rsp_count;
        n_discarded += exp_q.size();
        exp_q.delete();
        repeat (3) @(negedge PCLK);
        chk("t6_rst_no_rsp", rsp_count - rc0, 0);
        PRESET_n = 1'b1;
        @(negedge PCLK);
        chk("t6_post_busy", busy_o, 0);
        chk("t6_post_psel", PSEL_o, 0);
        chk("t6_post_no_rsp", rsp_count - rc0, 0);

        slave_waits = 0;
        push_cmd(0, 3, 0);
        push_cmd(0, 2, 0);
        drain("t6_post_drain");

        chk("rsp_total", rsp_count, n_pushed - n_discarded);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
